label_store_arbiter: RTL and testbench
======================================

Name: label_store_arbiter

Overview:
- Shares one dual-port wire-label store (2 write ports, 2 read ports, per-address written flag, synchronous clear) between N garbling cores.
- Each core issues label writes and label reads. Writes go through round-robin arbitration.
- A read is granted only when its address flag shows the label has been written. Unready reads are skipped so they do not block other cores.
- Sits between the core array and the label store. Also sequences the store clear between circuits.

Parameters:
- S, 20, label address width
- K, 128, label width in bits
- N, 4, number of requesting cores (2..16)
- NW, $clog2(N), requester index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- clr_req  in  1  request store clear (pulse)
- clr_busy  out  1  clear sequence in progress
- wr_req  in  N  per-core write request, held until granted
- wr_addr  in  N*S  per-core write address (core i at bits [i*S +: S])
- wr_data  in  N*K  per-core write label
- wr_gnt  out  N  write accepted this cycle (combinational)
- rd_req  in  N  per-core read request, held until granted
- rd_addr  in  N*S  per-core read address
- rd_gnt  out  N  read accepted this cycle (combinational)
- rd_rsp_valid  out  N  read data valid, one cycle after rd_gnt
- rd_rsp_data  out  N*K  registered read label
- miss_cnt  out  32  saturating count of examined-but-unready reads
- st_clr  out  1  store clear strobe
- st_wr_en_0, st_wr_en_1  out  1  store write enables
- st_wr_addr_0, st_wr_addr_1  out  S  store write addresses
- st_wr_data_0, st_wr_data_1  out  K  store write data
- st_rd_addr_0, st_rd_addr_1  out  S  store read addresses
- st_rd_ready_0, st_rd_ready_1  in  1  store flag for the read addresses (combinational)
- st_rd_data_0, st_rd_data_1  in  K  store read data (combinational)

Behaviour:
- Reset (rst=0): state=RUN, wr_ptr=rd_ptr=0, rd_rsp_valid=0, rd_rsp_data=0, miss_cnt=0. Combinational outputs evaluate to 0 (gnts, st_wr_en_*, st_clr, clr_busy).
- FSM states: RUN, CLEAR.
  - RUN to CLEAR: on clr_req=1 at a clock edge. Grants in the clr_req cycle itself proceed normally.
  - CLEAR: lasts exactly 1 cycle, then returns to RUN. During CLEAR: st_clr=1, clr_busy=1, all wr_gnt/rd_gnt=0, st_wr_en_*=0.
  - clr_req while in CLEAR is ignored.
- Write arbitration (RUN only):
  - Candidate A = first core with wr_req set, searching cyclically from wr_ptr. Candidate B = next such core after A.
  - A drives port 0, B drives port 1. Both are granted the same cycle and written at that edge.
  - If B's address equals A's, B is not granted and retries next cycle.
  - wr_ptr advances to (last granted index + 1) mod N. It is unchanged if nothing is granted.
- Read arbitration (RUN only):
  - Candidates C and D are chosen the same way from rd_ptr. Their addresses drive st_rd_addr_0 and st_rd_addr_1.
  - A candidate is granted iff its port's st_rd_ready=1. Unused read ports drive address 0.
  - rd_ptr advances to (last examined index + 1) mod N, whether or not the candidates were granted. This prevents head-of-line starvation.
  - Each examined-but-unready candidate adds 1 to miss_cnt (up to +2 per cycle). miss_cnt saturates at 2^32-1.
- Read response:
  - The edge after rd_gnt[i]: rd_rsp_valid[i]=1 for exactly one cycle, and rd_rsp_data slice i takes the store data.
  - Other rd_rsp_data slices hold their values.
- Read and write to the same address in the same cycle: the flag is not yet set, so the read is not granted and is retried. No forwarding.
- A response due in the cycle after a grant is still delivered, even if the FSM is in CLEAR.
- rst asserted mid-operation: pending responses are dropped and the pointers return to 0.

Decomposition:
- Package label_store_pkg: state enum {RUN, CLEAR}, MISS_CNT_W=32, and a function that finds the first set bit of an N-bit vector searching cyclically from a start index.
- Sub-module rr_pick2: given a request vector and a pointer, returns up to two one-hot picks plus their indices. It is instantiated twice, once for writes and once for reads.

Test Plan:
- Reset, then core 2 writes addr 0x00010 with data 0xA5..A5 -> wr_gnt=4'b0100, st_wr_en_0=1 that cycle. Core 2 then reads 0x00010 -> rd_gnt[2]=1, next cycle rd_rsp_valid=4'b0100 and data 0xA5..A5.
- Core 0 reads unwritten addr 0x00020 for 5 cycles -> no rd_gnt, miss_cnt=5. Core 1 then writes 0x00020 -> core 0 is granted the cycle after the write.
- All 4 cores hold wr_req with distinct addresses -> grant pairs {0,1},{2,3},{0,1}. Same request pattern for reads with all flags ready -> grant pairs {0,1},{2,3}.
- Cores 0 and 1 write the same addr 0x00005 in the same cycle -> only core 0 is granted. Core 1 is granted the next cycle, and the stored value is core 1's data.
- After writes, pulse clr_req -> next cycle st_clr=1 and clr_busy=1 with no grants. A subsequent read of a previously written address is not granted.
- Assert rst low mid-read (rd_gnt[3]=1 that cycle) -> no rd_rsp_valid after release, miss_cnt=0, next grants start from core 0.

Source files
------------

// File: rtl/label_store_pkg.sv
// Shared definitions for the label store arbiter.
//   state_e          : arbiter sequencing states (RUN, CLEAR)
//   MISS_CNT_W       : width of the saturating unready-read counter
//   MAX_REQ          : largest supported number of requesting cores
//   first_set_cyclic : index of the first set bit of a request vector,
//                      searching upward from a start index and wrapping
//                      at n; returns -1 when no bit is set.
package label_store_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int MISS_CNT_W = 32;
  localparam int MAX_REQ    = 16;

  // Only the low n bits of vec are meaningful; the search visits
  // start, start+1, ... wrapping back to 0 after n-1.
  function automatic int first_set_cyclic(input logic [MAX_REQ-1:0] vec,
                                          input int start,
                                          input int n);
    int j;
    int found;
    found = -1;
    for (int i = 0; i < MAX_REQ; i++) begin
      j = start + i;
      if (j >= n) j = j - n;
      if ((found < 0) && (i < n) && vec[j[3:0]]) found = j;
    end
    return found;
  endfunction

endpackage

// File: rtl/label_store_arbiter_rr_pick2.sv
// Round-robin double picker.
//   req      : request vector, one bit per core
//   ptr      : index where the cyclic search starts
//   valid_a  : a first requester exists
//   pick_a   : one-hot of the first requester at or after ptr
//   idx_a    : its index
//   valid_b  : a second requester exists
//   pick_b   : one-hot of the next requester after the first
//   idx_b    : its index
module rr_pick2
  import label_store_pkg::*;
#(
  parameter int N  = 4,
  parameter int NW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [NW-1:0] ptr,
  output logic          valid_a,
  output logic [N-1:0]  pick_a,
  output logic [NW-1:0] idx_a,
  output logic          valid_b,
  output logic [N-1:0]  pick_b,
  output logic [NW-1:0] idx_b
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] rest_ext;
  int                 res_a;
  int                 res_b;
  int                 start_b;

  // The second pick searches from just after the first one with the first
  // one masked out; everything between ptr and the first pick is already
  // known to be idle, so wrapping past ptr cannot reorder the winners.
  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    res_a            = first_set_cyclic(req_ext, int'(ptr), N);
    valid_a          = (res_a >= 0);
    idx_a            = valid_a ? NW'(res_a) : '0;
    pick_a           = valid_a ? (N'(1) << idx_a) : '0;
    rest_ext         = req_ext & ~(MAX_REQ'(valid_a) << idx_a);
    start_b          = (res_a + 1 >= N) ? 0 : res_a + 1;
    res_b            = first_set_cyclic(rest_ext, start_b, N);
    valid_b          = valid_a && (res_b >= 0);
    idx_b            = valid_b ? NW'(res_b) : '0;
    pick_b           = valid_b ? (N'(1) << idx_b) : '0;
  end

endmodule

// File: rtl/label_store_arbiter.sv
// Arbiter sharing one dual-port wire-label store between N garbling cores.
//   clk, rst          : clock, asynchronous active-low reset
//   clr_req/clr_busy  : request a store clear / clear cycle in progress
//   wr_req/addr/data  : per-core label writes, wr_gnt accepts them
//   rd_req/addr       : per-core label reads, rd_gnt accepts them
//   rd_rsp_valid/data : registered read response, one cycle after rd_gnt
//   miss_cnt          : saturating count of examined-but-unready reads
//   st_*              : label store interface (clear, 2 write, 2 read ports)
module label_store_arbiter
  import label_store_pkg::*;
#(
  parameter int S  = 20,
  parameter int K  = 128,
  parameter int N  = 4,
  parameter int NW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  clr_busy,
  input  logic [N-1:0]          wr_req,
  input  logic [N*S-1:0]        wr_addr,
  input  logic [N*K-1:0]        wr_data,
  output logic [N-1:0]          wr_gnt,
  input  logic [N-1:0]          rd_req,
  input  logic [N*S-1:0]        rd_addr,
  output logic [N-1:0]          rd_gnt,
  output logic [N-1:0]          rd_rsp_valid,
  output logic [N*K-1:0]        rd_rsp_data,
  output logic [MISS_CNT_W-1:0] miss_cnt,
  output logic                  st_clr,
  output logic                  st_wr_en_0,
  output logic                  st_wr_en_1,
  output logic [S-1:0]          st_wr_addr_0,
  output logic [S-1:0]          st_wr_addr_1,
  output logic [K-1:0]          st_wr_data_0,
  output logic [K-1:0]          st_wr_data_1,
  output logic [S-1:0]          st_rd_addr_0,
  output logic [S-1:0]          st_rd_addr_1,
  input  logic                  st_rd_ready_0,
  input  logic                  st_rd_ready_1,
  input  logic [K-1:0]          st_rd_data_0,
  input  logic [K-1:0]          st_rd_data_1
);

  localparam int MW1 = MISS_CNT_W + 1;

  state_e                state_q, state_d;
  logic [NW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [N-1:0]          rd_rsp_valid_q, rd_rsp_valid_d;
  logic [N*K-1:0]        rd_rsp_data_q, rd_rsp_data_d;
  logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic          w_valid_a, w_valid_b, r_valid_a, r_valid_b;
  logic [N-1:0]  w_pick_a, w_pick_b, r_pick_a, r_pick_b;
  logic [NW-1:0] w_idx_a, w_idx_b, r_idx_a, r_idx_b;

  logic          run;
  logic [S-1:0]  wa_addr, wb_addr, ra_addr, rb_addr;
  logic [K-1:0]  wa_data, wb_data;
  logic          wa_ok, wb_ok;
  logic          ra_exam, rb_exam, ra_ok, rb_ok;
  logic [1:0]    miss_inc;
  logic [MW1-1:0] miss_sum;

  rr_pick2 #(.N(N), .NW(NW)) u_wr_pick (
    .req     (wr_req),
    .ptr     (wr_ptr_q),
    .valid_a (w_valid_a),
    .pick_a  (w_pick_a),
    .idx_a   (w_idx_a),
    .valid_b (w_valid_b),
    .pick_b  (w_pick_b),
    .idx_b   (w_idx_b)
  );

  rr_pick2 #(.N(N), .NW(NW)) u_rd_pick (
    .req     (rd_req),
    .ptr     (rd_ptr_q),
    .valid_a (r_valid_a),
    .pick_a  (r_pick_a),
    .idx_a   (r_idx_a),
    .valid_b (r_valid_b),
    .pick_b  (r_pick_b),
    .idx_b   (r_idx_b)
  );

  function automatic logic [NW-1:0] ptr_after(input logic [NW-1:0] idx);
    return (int'(idx) == N - 1) ? '0 : idx + NW'(1);
  endfunction

  always_comb begin
    wa_addr = '0;
    wa_data = '0;
    wb_addr = '0;
    wb_data = '0;
    ra_addr = '0;
    rb_addr = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_a[i]) begin
        wa_addr = wr_addr[i*S +: S];
        wa_data = wr_data[i*K +: K];
      end
      if (w_pick_b[i]) begin
        wb_addr = wr_addr[i*S +: S];
        wb_data = wr_data[i*K +: K];
      end
      if (r_pick_a[i]) ra_addr = rd_addr[i*S +: S];
      if (r_pick_b[i]) rb_addr = rd_addr[i*S +: S];
    end
  end

  // Grants are suppressed while reset is held and during the clear cycle.
  // Two writes to one address would collide in the store, so the second
  // one waits. Reads are granted purely on the store's written flag; a
  // write landing this same edge is not forwarded.
  always_comb begin
    run          = rst && (state_q == RUN);
    wa_ok        = run && w_valid_a;
    wb_ok        = run && w_valid_b && (wb_addr != wa_addr);
    wr_gnt       = (wa_ok ? w_pick_a : '0) | (wb_ok ? w_pick_b : '0);
    st_wr_en_0   = wa_ok;
    st_wr_en_1   = wb_ok;
    st_wr_addr_0 = wa_ok ? wa_addr : '0;
    st_wr_addr_1 = wb_ok ? wb_addr : '0;
    st_wr_data_0 = wa_ok ? wa_data : '0;
    st_wr_data_1 = wb_ok ? wb_data : '0;

    ra_exam      = run && r_valid_a;
    rb_exam      = run && r_valid_b;
    st_rd_addr_0 = ra_exam ? ra_addr : '0;
    st_rd_addr_1 = rb_exam ? rb_addr : '0;
    ra_ok        = ra_exam && st_rd_ready_0;
    rb_ok        = rb_exam && st_rd_ready_1;
    rd_gnt       = (ra_ok ? r_pick_a : '0) | (rb_ok ? r_pick_b : '0);

    st_clr       = rst && (state_q == CLEAR);
    clr_busy     = st_clr;
  end

  // The read pointer moves past every examined core even when it was not
  // ready, so an unwritten label cannot starve the cores behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (clr_req) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      default: state_d = RUN;
    endcase

    wr_ptr_d = wb_ok ? ptr_after(w_idx_b) : (wa_ok ? ptr_after(w_idx_a) : wr_ptr_q);
    rd_ptr_d = rb_exam ? ptr_after(r_idx_b) : (ra_exam ? ptr_after(r_idx_a) : rd_ptr_q);

    miss_inc   = 2'(ra_exam && !st_rd_ready_0) + 2'(rb_exam && !st_rd_ready_1);
    miss_sum   = {1'b0, miss_cnt_q} + MW1'(miss_inc);
    miss_cnt_d = miss_sum[MISS_CNT_W] ? '1 : miss_sum[MISS_CNT_W-1:0];

    rd_rsp_valid_d = rd_gnt;
    rd_rsp_data_d  = rd_rsp_data_q;
    for (int i = 0; i < N; i++) begin
      if (ra_ok && r_pick_a[i]) rd_rsp_data_d[i*K +: K] = st_rd_data_0;
      else if (rb_ok && r_pick_b[i]) rd_rsp_data_d[i*K +: K] = st_rd_data_1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rd_rsp_valid_q <= '0;
      rd_rsp_data_q  <= '0;
      miss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      rd_rsp_data_q  <= rd_rsp_data_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rd_rsp_data  = rd_rsp_data_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_label_store_arbiter.sv
// Testbench for label_store_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a behavioural model of the arbiter.
// The bench also plays the external label store; it only decodes the low
// six address bits, and every address used here fits in that range.
module tb_label_store_arbiter;

  localparam int S  = 20;
  localparam int K  = 128;
  localparam int N  = 4;
  localparam int NW = 2;

  typedef int intq_t[$];

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clr_req;
  logic           clr_busy;
  logic [N-1:0]   wr_req;
  logic [N*S-1:0] wr_addr;
  logic [N*K-1:0] wr_data;
  logic [N-1:0]   wr_gnt;
  logic [N-1:0]   rd_req;
  logic [N*S-1:0] rd_addr;
  logic [N-1:0]   rd_gnt;
  logic [N-1:0]   rd_rsp_valid;
  logic [N*K-1:0] rd_rsp_data;
  logic [31:0]    miss_cnt;
  logic           st_clr;
  logic           st_wr_en_0, st_wr_en_1;
  logic [S-1:0]   st_wr_addr_0, st_wr_addr_1;
  logic [K-1:0]   st_wr_data_0, st_wr_data_1;
  logic [S-1:0]   st_rd_addr_0, st_rd_addr_1;
  logic           st_rd_ready_0, st_rd_ready_1;
  logic [K-1:0]   st_rd_data_0, st_rd_data_1;

  // Per-core stimulus as the cores see it
  logic [N-1:0] wr_req_v, rd_req_v;
  logic [S-1:0] wr_addr_v [N];
  logic [K-1:0] wr_data_v [N];
  logic [S-1:0] rd_addr_v [N];
  logic         clr_req_v;

  // External label store
  bit           s_flag [64];
  bit   [K-1:0] s_data [64];

  // Reference model state
  bit           m_clear;
  int           m_wptr, m_rptr;
  logic [31:0]  m_miss;
  logic [N-1:0] m_rsp_valid;
  logic [K-1:0] m_rsp_data [N];
  bit           m_flag [64];
  bit   [K-1:0] m_data [64];

  // Model expectations for the current cycle
  logic [N-1:0] e_wr_gnt, e_rd_gnt;
  logic         e_wen0, e_wen1, e_clr;
  logic [S-1:0] e_waddr0, e_waddr1, e_raddr0, e_raddr1;
  logic [K-1:0] e_wdata0, e_wdata1;
  int           e_misses, e_wlast, e_rlast;

  int test_count = 0;
  int fail_count = 0;

  label_store_arbiter #(.S(S), .K(K), .N(N), .NW(NW)) dut (
    .clk           (clk),
    .rst           (rst),
    .clr_req       (clr_req),
    .clr_busy      (clr_busy),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_gnt        (wr_gnt),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data),
    .miss_cnt      (miss_cnt),
    .st_clr        (st_clr),
    .st_wr_en_0    (st_wr_en_0),
    .st_wr_en_1    (st_wr_en_1),
    .st_wr_addr_0  (st_wr_addr_0),
    .st_wr_addr_1  (st_wr_addr_1),
    .st_wr_data_0  (st_wr_data_0),
    .st_wr_data_1  (st_wr_data_1),
    .st_rd_addr_0  (st_rd_addr_0),
    .st_rd_addr_1  (st_rd_addr_1),
    .st_rd_ready_0 (st_rd_ready_0),
    .st_rd_ready_1 (st_rd_ready_1),
    .st_rd_data_0  (st_rd_data_0),
    .st_rd_data_1  (st_rd_data_1)
  );

  always #5 clk = ~clk;

  // Pack per-core stimulus onto the DUT buses
  always_comb begin
    wr_req  = wr_req_v;
    rd_req  = rd_req_v;
    clr_req = clr_req_v;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      wr_addr[i*S +: S] = wr_addr_v[i];
      wr_data[i*K +: K] = wr_data_v[i];
      rd_addr[i*S +: S] = rd_addr_v[i];
    end
  end

  // Label store: written flags survive reset, cleared only by st_clr
  always @(posedge clk) begin
    if (st_clr) for (int j = 0; j < 64; j++) s_flag[j] <= 1'b0;
    if (st_wr_en_0) begin
      s_flag[st_wr_addr_0[5:0]] <= 1'b1;
      s_data[st_wr_addr_0[5:0]] <= st_wr_data_0;
    end
    if (st_wr_en_1) begin
      s_flag[st_wr_addr_1[5:0]] <= 1'b1;
      s_data[st_wr_addr_1[5:0]] <= st_wr_data_1;
    end
  end

  assign st_rd_ready_0 = s_flag[st_rd_addr_0[5:0]];
  assign st_rd_ready_1 = s_flag[st_rd_addr_1[5:0]];
  assign st_rd_data_0  = s_data[st_rd_addr_0[5:0]];
  assign st_rd_data_1  = s_data[st_rd_addr_1[5:0]];

  // Requesting cores listed in round-robin order starting at ptr
  function automatic intq_t requestersFrom(input logic [N-1:0] req, input int ptr);
    intq_t q;
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) q.push_back((ptr + k) % N);
    end
    return q;
  endfunction

  task automatic modelReset();
    m_clear     = 1'b0;
    m_wptr      = 0;
    m_rptr      = 0;
    m_miss      = '0;
    m_rsp_valid = '0;
    for (int i = 0; i < N; i++) m_rsp_data[i] = '0;
  endtask

  task automatic modelEval();
    intq_t q;
    logic [S-1:0] a;
    e_wr_gnt = '0; e_rd_gnt = '0;
    e_wen0 = 1'b0; e_wen1 = 1'b0;
    e_waddr0 = '0; e_waddr1 = '0; e_wdata0 = '0; e_wdata1 = '0;
    e_raddr0 = '0; e_raddr1 = '0;
    e_misses = 0; e_wlast = -1; e_rlast = -1;
    e_clr = rst && m_clear;
    if (rst && !m_clear) begin
      q = requestersFrom(wr_req_v, m_wptr);
      if (q.size() > 0) begin
        e_wr_gnt[q[0]] = 1'b1; e_wen0 = 1'b1;
        e_waddr0 = wr_addr_v[q[0]]; e_wdata0 = wr_data_v[q[0]];
        e_wlast = q[0];
      end
      if (q.size() > 1 && wr_addr_v[q[1]] != wr_addr_v[q[0]]) begin
        e_wr_gnt[q[1]] = 1'b1; e_wen1 = 1'b1;
        e_waddr1 = wr_addr_v[q[1]]; e_wdata1 = wr_data_v[q[1]];
        e_wlast = q[1];
      end
      q = requestersFrom(rd_req_v, m_rptr);
      for (int p = 0; p < 2 && p < q.size(); p++) begin
        a = rd_addr_v[q[p]];
        if (p == 0) e_raddr0 = a; else e_raddr1 = a;
        if (m_flag[a[5:0]]) e_rd_gnt[q[p]] = 1'b1;
        else e_misses++;
        e_rlast = q[p];
      end
    end
  endtask

  task automatic modelCommit();
    longint sum;
    bit next_clear;
    logic [S-1:0] a;
    next_clear = !m_clear && clr_req_v;
    for (int i = 0; i < N; i++) begin
      m_rsp_valid[i] = e_rd_gnt[i];
      a = rd_addr_v[i];
      if (e_rd_gnt[i]) m_rsp_data[i] = m_data[a[5:0]];
    end
    if (m_clear) for (int j = 0; j < 64; j++) m_flag[j] = 1'b0;
    if (e_wen0) begin m_flag[e_waddr0[5:0]] = 1'b1; m_data[e_waddr0[5:0]] = e_wdata0; end
    if (e_wen1) begin m_flag[e_waddr1[5:0]] = 1'b1; m_data[e_waddr1[5:0]] = e_wdata1; end
    if (e_wlast >= 0) m_wptr = (e_wlast + 1) % N;
    if (e_rlast >= 0) m_rptr = (e_rlast + 1) % N;
    sum = longint'(m_miss) + longint'(e_misses);
    m_miss = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
    m_clear = next_clear;
  endtask

  task automatic checkValue(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample away from the active edge and compare everything against the model
  task automatic checkOutput();
    @(negedge clk);
    modelEval();
    checkValue("wr_gnt", K'(wr_gnt), K'(e_wr_gnt));
    checkValue("rd_gnt", K'(rd_gnt), K'(e_rd_gnt));
    checkValue("st_wr_en_0", K'(st_wr_en_0), K'(e_wen0));
    checkValue("st_wr_en_1", K'(st_wr_en_1), K'(e_wen1));
    if (e_wen0) begin
      checkValue("st_wr_addr_0", K'(st_wr_addr_0), K'(e_waddr0));
      checkValue("st_wr_data_0", st_wr_data_0, e_wdata0);
    end
    if (e_wen1) begin
      checkValue("st_wr_addr_1", K'(st_wr_addr_1), K'(e_waddr1));
      checkValue("st_wr_data_1", st_wr_data_1, e_wdata1);
    end
    checkValue("st_rd_addr_0", K'(st_rd_addr_0), K'(e_raddr0));
    checkValue("st_rd_addr_1", K'(st_rd_addr_1), K'(e_raddr1));
    checkValue("st_clr", K'(st_clr), K'(e_clr));
    checkValue("clr_busy", K'(clr_busy), K'(e_clr));
    checkValue("rd_rsp_valid", K'(rd_rsp_valid), K'(m_rsp_valid));
    for (int i = 0; i < N; i++)
      checkValue($sformatf("rd_rsp_data[%0d]", i), rd_rsp_data[i*K +: K], m_rsp_data[i]);
    checkValue("miss_cnt", K'(miss_cnt), K'(m_miss));
  endtask

  // Cross the clock edge; granted requests retire, clear requests are pulses
  task automatic advance();
    @(posedge clk);
    if (!rst) modelReset();
    else modelCommit();
    #1;
    wr_req_v  = wr_req_v & ~e_wr_gnt;
    rd_req_v  = rd_req_v & ~e_rd_gnt;
    clr_req_v = 1'b0;
  endtask

  task automatic stepCycle();
    checkOutput();
    advance();
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (!wr_req_v[i] && $urandom_range(0, 2) == 0) begin
        wr_req_v[i]  = 1'b1;
        wr_addr_v[i] = S'($urandom_range(0, 15));
        wr_data_v[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!rd_req_v[i] && $urandom_range(0, 2) == 0) begin
        rd_req_v[i]  = 1'b1;
        rd_addr_v[i] = S'($urandom_range(0, 15));
      end
    end
    clr_req_v = ($urandom_range(0, 39) == 0);
  endtask

  logic [K-1:0] saved_a, saved_b;

  initial begin
    wr_req_v = '0; rd_req_v = '0; clr_req_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      wr_addr_v[i] = '0; wr_data_v[i] = '0; rd_addr_v[i] = '0;
    end
    modelReset();
    #1 rst = 1'b0;

    // Reset state
    checkOutput();
    checkValue("reset miss_cnt", K'(miss_cnt), '0);
    checkValue("reset rd_rsp_valid", K'(rd_rsp_valid), '0);
    checkValue("reset clr_busy", K'(clr_busy), '0);
    advance();
    stepCycle();
    rst = 1'b1;

    // All four cores write distinct addresses, twice round
    wr_req_v = 4'hF;
    for (int i = 0; i < N; i++) begin
      wr_addr_v[i] = S'(8 + i);
      wr_data_v[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    checkOutput(); checkValue("rr wr pair 01", K'(wr_gnt), K'(4'b0011)); advance();
    checkOutput(); checkValue("rr wr pair 23", K'(wr_gnt), K'(4'b1100)); advance();
    wr_req_v = 4'hF;
    checkOutput(); checkValue("rr wr pair 01 again", K'(wr_gnt), K'(4'b0011)); advance();
    stepCycle();

    // All four cores read those addresses, all flags ready
    rd_req_v = 4'hF;
    for (int i = 0; i < N; i++) rd_addr_v[i] = S'(8 + i);
    checkOutput(); checkValue("rr rd pair 01", K'(rd_gnt), K'(4'b0011)); advance();
    checkOutput(); checkValue("rr rd pair 23", K'(rd_gnt), K'(4'b1100)); advance();
    stepCycle();

    // Core 2 writes then reads back a label
    wr_req_v[2] = 1'b1; wr_addr_v[2] = S'(20'h00010); wr_data_v[2] = {16{8'hA5}};
    checkOutput();
    checkValue("c2 wr_gnt", K'(wr_gnt), K'(4'b0100));
    checkValue("c2 st_wr_en_0", K'(st_wr_en_0), K'(1'b1));
    advance();
    rd_req_v[2] = 1'b1; rd_addr_v[2] = S'(20'h00010);
    checkOutput(); checkValue("c2 rd_gnt", K'(rd_gnt[2]), K'(1'b1)); advance();
    checkOutput();
    checkValue("c2 rsp_valid", K'(rd_rsp_valid), K'(4'b0100));
    checkValue("c2 rsp_data", rd_rsp_data[2*K +: K], {16{8'hA5}});
    advance();

    // Core 0 waits on an unwritten label, then core 1 writes it
    rd_req_v[0] = 1'b1; rd_addr_v[0] = S'(20'h00020);
    for (int c = 0; c < 5; c++) begin
      checkOutput(); checkValue("unready rd_gnt", K'(rd_gnt), '0); advance();
    end
    saved_a = {$urandom, $urandom, $urandom, $urandom};
    wr_req_v[1] = 1'b1; wr_addr_v[1] = S'(20'h00020); wr_data_v[1] = saved_a;
    checkOutput();
    checkValue("miss_cnt after 5", K'(miss_cnt), K'(32'd5));
    checkValue("c1 wr_gnt", K'(wr_gnt), K'(4'b0010));
    checkValue("same-cycle rd not granted", K'(rd_gnt), '0);
    advance();
    checkOutput(); checkValue("c0 granted after write", K'(rd_gnt), K'(4'b0001)); advance();
    checkOutput(); checkValue("c0 rsp_data", rd_rsp_data[0 +: K], saved_a); advance();

    // Two writes to one address: the second waits a cycle
    saved_a = {$urandom, $urandom, $urandom, $urandom};
    saved_b = {$urandom, $urandom, $urandom, $urandom};
    wr_req_v[1:0] = 2'b11;
    wr_addr_v[0] = S'(20'h00005); wr_data_v[0] = saved_a;
    wr_addr_v[1] = S'(20'h00005); wr_data_v[1] = saved_b;
    checkOutput(); checkValue("collide first", K'(wr_gnt), K'(4'b0001)); advance();
    checkOutput(); checkValue("collide second", K'(wr_gnt), K'(4'b0010)); advance();
    rd_req_v[2] = 1'b1; rd_addr_v[2] = S'(20'h00005);
    stepCycle();
    checkOutput(); checkValue("collide stored value", rd_rsp_data[2*K +: K], saved_b); advance();

    // Clear: grants proceed in the request cycle, none during the clear
    clr_req_v = 1'b1;
    wr_req_v[3] = 1'b1; wr_addr_v[3] = S'(20'h00030); wr_data_v[3] = {4{$urandom}};
    checkOutput(); checkValue("clr_req cycle wr_gnt", K'(wr_gnt), K'(4'b1000)); advance();
    rd_req_v[3] = 1'b1; rd_addr_v[3] = S'(20'h00010);
    checkOutput();
    checkValue("clear st_clr", K'(st_clr), K'(1'b1));
    checkValue("clear clr_busy", K'(clr_busy), K'(1'b1));
    checkValue("clear rd_gnt", K'(rd_gnt), '0);
    advance();
    checkOutput();
    checkValue("post-clear rd_gnt", K'(rd_gnt), '0);
    checkValue("post-clear st_clr", K'(st_clr), '0);
    advance();
    rd_req_v[3] = 1'b0;

    // Reset while a read is being granted
    wr_req_v[3] = 1'b1; wr_addr_v[3] = S'(20'h00031); wr_data_v[3] = {4{$urandom}};
    stepCycle();
    rd_req_v[3] = 1'b1; rd_addr_v[3] = S'(20'h00031);
    checkOutput(); checkValue("pre-reset rd_gnt", K'(rd_gnt), K'(4'b1000));
    #1 rst = 1'b0;
    wr_req_v = '0; rd_req_v = '0;
    advance();
    checkOutput();
    checkValue("reset drops rsp", K'(rd_rsp_valid), '0);
    checkValue("reset miss_cnt", K'(miss_cnt), '0);
    advance();
    rst = 1'b1;
    wr_req_v = 4'hF;
    for (int i = 0; i < N; i++) begin
      wr_addr_v[i] = S'(56 + i);
      wr_data_v[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    checkOutput(); checkValue("post-reset from core 0", K'(wr_gnt), K'(4'b0011)); advance();
    stepCycle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      applyStimulus();
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
